// File: rtl/wordcopy_pipe.sv
// Pipelined Avalon-MM word copy / pattern fill engine with an in-order read-data FIFO.
// Define WORDCOPY_PIPE_IRQ_EN to add a completion interrupt (irq, cleared via register 6).
module wordcopy_pipe #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
`ifdef WORDCOPY_PIPE_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned AddrShift = (DATA_W == 64) ? 3 : 2;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Control registers
  logic [31:0] dst_q, src_q, num_q, mode_q, pattern_q;

  // Progress counters
  logic [31:0]   reads_issued_q, reads_issued_d;
  logic [31:0]   writes_issued_q, writes_issued_d;
  logic [31:0]   words_written_q, words_written_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;

  // Read-data FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_count_q, fifo_count_d;

  // Master command currently presented on the bus
  logic              cmd_read_q, cmd_read_d;
  logic              cmd_write_q, cmd_write_d;
  logic [31:0]       cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic reg_wr, start, in_run, fill_mode;
  logic cmd_busy, cmd_done, slot_free;
  logic fifo_empty, fifo_full, push, pop;
  logic can_write, can_read, issue_write, issue_read;
  logic [DATA_W-1:0] fill_ext;

  assign slave_waitrequest = (state_q != StIdle);
  assign reg_wr     = slave_write && (state_q == StIdle);
  assign start      = reg_wr && (slave_address == 4'd0);
  assign in_run     = (state_q == StRun);
  assign fill_mode  = mode_q[0];
  assign fill_ext   = DATA_W'(pattern_q);

  assign cmd_busy   = cmd_read_q || cmd_write_q;
  assign cmd_done   = cmd_busy && !master_waitrequest;
  // A new command may be loaded when the bus is idle or the current one completes now.
  assign slot_free  = !cmd_busy || !master_waitrequest;

  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == CntW'(FIFO_DEPTH));
  assign push       = in_run && master_readdatavalid;

  assign can_write  = in_run && (fill_mode ? (writes_issued_q < num_q) : !fifo_empty);
  assign can_read   = in_run && !fill_mode && (reads_issued_q < num_q) &&
                      (32'(outstanding_q) < MAX_OUTSTANDING) &&
                      ((32'(fifo_count_q) + 32'(outstanding_q)) < FIFO_DEPTH);
  assign issue_write = slot_free && can_write;
  assign issue_read  = slot_free && can_read && !issue_write;
  assign pop         = issue_write && !fill_mode;

  assign master_read      = cmd_read_q;
  assign master_write     = cmd_write_q;
  assign master_address   = cmd_addr_q;
  assign master_writedata = cmd_wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (words_written_q == num_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reads_issued_d  = reads_issued_q;
    writes_issued_d = writes_issued_q;
    words_written_d = words_written_q;
    outstanding_d   = outstanding_q;
    if (start) begin
      reads_issued_d  = '0;
      writes_issued_d = '0;
      words_written_d = '0;
      outstanding_d   = '0;
    end else begin
      if (issue_read)  reads_issued_d  = reads_issued_q + 32'd1;
      if (issue_write) writes_issued_d = writes_issued_q + 32'd1;
      if (cmd_done && cmd_write_q) words_written_d = words_written_q + 32'd1;
      if (issue_read)  outstanding_d = outstanding_d + OutW'(1);
      if (push)        outstanding_d = outstanding_d - OutW'(1);
    end
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CntW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CntW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_comb begin
    cmd_read_d  = cmd_read_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (issue_write) begin
      cmd_read_d  = 1'b0;
      cmd_write_d = 1'b1;
      cmd_addr_d  = dst_q + (writes_issued_q << AddrShift);
      cmd_wdata_d = fill_mode ? fill_ext : fifo_mem[rd_ptr_q];
    end else if (issue_read) begin
      cmd_read_d  = 1'b1;
      cmd_write_d = 1'b0;
      cmd_addr_d  = src_q + (reads_issued_q << AddrShift);
    end else if (cmd_done) begin
      cmd_read_d  = 1'b0;
      cmd_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      dst_q           <= '0;
      src_q           <= '0;
      num_q           <= '0;
      mode_q          <= '0;
      pattern_q       <= '0;
      reads_issued_q  <= '0;
      writes_issued_q <= '0;
      words_written_q <= '0;
      outstanding_q   <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      cmd_read_q      <= 1'b0;
      cmd_write_q     <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (reg_wr) begin
        case (slave_address)
          4'd1:    dst_q     <= slave_writedata;
          4'd2:    src_q     <= slave_writedata;
          4'd3:    num_q     <= slave_writedata;
          4'd4:    mode_q    <= slave_writedata;
          4'd5:    pattern_q <= slave_writedata;
          default: ;
        endcase
      end
      reads_issued_q  <= reads_issued_d;
      writes_issued_q <= writes_issued_d;
      words_written_q <= words_written_d;
      outstanding_q   <= outstanding_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fifo_count_q    <= fifo_count_d;
      cmd_read_q      <= cmd_read_d;
      cmd_write_q     <= cmd_write_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_wdata_q     <= cmd_wdata_d;
    end
  end

  // Storage only; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= master_readdata;
  end

`ifdef WORDCOPY_PIPE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (state_q == StRun && state_d == StDone) begin
      irq_q <= 1'b1;
    end else if (reg_wr && slave_address == 4'd6) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = words_written_q;
        4'd1:    slave_readdata = dst_q;
        4'd2:    slave_readdata = src_q;
        4'd3:    slave_readdata = num_q;
        4'd4:    slave_readdata = mode_q;
        4'd5:    slave_readdata = pattern_q;
`ifdef WORDCOPY_PIPE_IRQ_EN
        4'd6:    slave_readdata = {31'b0, irq_q};
`endif
        default: slave_readdata = '0;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
